mda_adc_scan: RTL

Parametrised multi-channel scanning front end for the DE0-Nano ADC path, sitting between the Avalon-MM slave bus and the `mda_adc_controller` SPI engine. It sequences conversions over a programmable channel mask and discards the pipelined configuration conversion after each channel switch. Each result is an average of 2^AVG_LOG2 samples, stored both in a per-channel "latest" register and in a tagged sample FIFO. This replaces the single-channel, single-result depth-sensor ADC interface with a scan/oversample/buffer block on one clock domain.

---
 rtl/mda_adc_scan.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mda_adc_scan.sv
// Multi-channel ADC scan sequencer: walks a channel mask, averages 2^AVG_LOG2 conversions
// per channel and stores each result in a per-channel LATEST register and a tagged FIFO.
module mda_adc_scan #(
    parameter int NUM_CH     = 8,
    parameter int DATA_W     = 12,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic              slave_clk,
    input  logic              slave_reset_n,
    input  logic              slave_chipselect_n,
    input  logic [3:0]        slave_addr,
    input  logic              slave_read_n,
    input  logic              slave_write_n,
    input  logic [15:0]       slave_writedata,
    output logic [15:0]       slave_readdata,
    output logic              measure_start,
    output logic [2:0]        measure_ch,
    input  logic              measure_done,
    input  logic [DATA_W-1:0] measure_dataread,
    output logic [2:0]        scan_state
);

    localparam int ACC_W   = DATA_W + AVG_LOG2;
    localparam int CNT_W   = AVG_LOG2 + 1;
    localparam int AVG_N   = 1 << AVG_LOG2;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int ENTRY_W = 3 + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_ACC    = 3'd4,
        S_PUSH   = 3'd5
    } state_t;

    state_t              state;
    logic                enable, continuous, overflow, timeout, scan_done;
    logic [NUM_CH-1:0]   ch_mask;
    logic [2:0]          cur_ch;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic                discard;
    logic [DATA_W-1:0]   sample;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                done_q;
    logic [DATA_W-1:0]   latest [NUM_CH];

    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    level;
    logic                rd_prev;

    logic bus_rd, bus_wr, rd_first, ctrl_wr, mask_wr, flush, pop_req;
    logic fifo_full, fifo_empty, push_req, do_push, do_pop, ovf_set;
    logic done_rise, mask_any, next_found;
    logic [2:0] lowest_ch, next_ch;
    logic [DATA_W-1:0] result;
    logic [ENTRY_W-1:0] head;
    logic [15:0] status, rd_mux;
    logic unused_wdata;

    assign scan_state = state;
    assign unused_wdata = ^slave_writedata[15:NUM_CH];

    assign bus_rd   = !slave_chipselect_n && !slave_read_n;
    assign bus_wr   = !slave_chipselect_n && !slave_write_n;
    // A read access pops at most once: only its first strobed cycle counts.
    assign rd_first = bus_rd && !rd_prev;
    assign ctrl_wr  = bus_wr && (slave_addr == 4'd0);
    assign mask_wr  = bus_wr && (slave_addr == 4'd1);
    assign flush    = ctrl_wr && slave_writedata[2];
    assign pop_req  = rd_first && (slave_addr == 4'd2);

    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign push_req   = (state == S_PUSH);
    assign do_pop     = pop_req && !fifo_empty && !flush;
    assign do_push    = push_req && !flush && (!fifo_full || do_pop);
    assign ovf_set    = push_req && !flush && fifo_full && !do_pop;
    assign result     = acc[ACC_W-1:AVG_LOG2];
    assign head       = mem[rd_ptr];

    // Handshake: measure_start is a one-cycle request; completion is the rising edge of
    // measure_done, when measure_dataread carries the result of the previous request, so
    // the first conversion after a channel switch is a throw-away.
    assign done_rise = measure_done && !done_q;
    assign mask_any  = |ch_mask;

    always_comb begin
        lowest_ch  = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                lowest_ch = 3'(i);
                if (i > int'(cur_ch)) begin
                    next_ch    = 3'(i);
                    next_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        status = {8'(level), 2'b00, scan_done, timeout, overflow, fifo_full, fifo_empty,
                  (state != S_IDLE)};
        rd_mux = '0;
        case (slave_addr)
            4'd0: rd_mux = status;
            4'd1: rd_mux = 16'(ch_mask);
            4'd2: if (!fifo_empty) rd_mux = {head[ENTRY_W-1 -: 3], 13'(head[DATA_W-1:0])};
            default: begin
                if (slave_addr >= 4'd8 && int'(slave_addr) < 8 + NUM_CH)
                    rd_mux = 16'(latest[slave_addr[2:0]]);
            end
        endcase
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            slave_readdata <= '0;
            rd_prev        <= 1'b0;
        end else begin
            rd_prev <= bus_rd;
            if (rd_first) slave_readdata <= rd_mux;
        end
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge slave_clk) begin
        if (do_push) mem[wr_ptr] <= {cur_ch, result};
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            state         <= S_IDLE;
            enable        <= 1'b0;
            continuous    <= 1'b0;
            overflow      <= 1'b0;
            timeout       <= 1'b0;
            scan_done     <= 1'b0;
            ch_mask       <= '1;
            cur_ch        <= '0;
            measure_ch    <= '0;
            measure_start <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            discard       <= 1'b0;
            sample        <= '0;
            tmo_cnt       <= '0;
            done_q        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) latest[i] <= '0;
        end else begin
            done_q        <= measure_done;
            measure_start <= 1'b0;
            if (ovf_set) overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (enable && mask_any) begin
                        cur_ch <= lowest_ch;
                        state  <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        measure_ch    <= cur_ch;
                        acc           <= '0;
                        cnt           <= '0;
                        discard       <= 1'b1;
                        measure_start <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_rise) begin
                        sample <= measure_dataread;
                        state  <= enable ? S_ACC : S_IDLE;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        enable  <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_ACC: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (discard) begin
                        discard       <= 1'b0;
                        measure_start <= 1'b1;
                        state         <= S_START;
                    end else begin
                        acc <= acc + ACC_W'(sample);
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(AVG_N - 1)) begin
                            state <= S_PUSH;
                        end else begin
                            measure_start <= 1'b1;
                            state         <= S_START;
                        end
                    end
                end
                S_PUSH: begin
                    latest[cur_ch] <= result;
                    if (!enable || !mask_any) begin
                        state <= S_IDLE;
                    end else if (!next_found && !continuous) begin
                        scan_done <= 1'b1;
                        enable    <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cur_ch <= next_found ? next_ch : lowest_ch;
                        state  <= S_SELECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Software writes land after the sequencer so they win a same-cycle conflict.
            if (ctrl_wr) begin
                enable     <= slave_writedata[0];
                continuous <= slave_writedata[1];
                if (slave_writedata[0]) scan_done <= 1'b0;
                if (slave_writedata[3]) begin
                    overflow <= 1'b0;
                    timeout  <= 1'b0;
                end
            end
            if (mask_wr) ch_mask <= slave_writedata[NUM_CH-1:0];
        end
    end

endmodule
